bcd_count_ctrl: RTL and testbench

//  Sequencer for the 2-digit BCD up-counter (7-bit max_count, run, digit_1/digit_2).

---
 rtl/bcd_count_ctrl.sv | 142 ++++++++++++++
 tb/tb_bcd_count_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_ctrl.sv
// Sequencer for a 2-digit BCD up-counter.
// It latches a requested terminal value and clamps it to 0..99.
// It clears the counter by holding run low, then releases run and watches the digits.
// It flags completion or an error, and can optionally re-arm for repeated passes.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          1-cycle pulse: latch max_req and begin a pass (IDLE/HOLD only)
//   abort          1-cycle pulse: return to IDLE (wins over start)
//   repeat_en      1 = re-arm automatically after each completed pass
//   max_req[6:0]   requested terminal count, binary 0..127
//   digit_1[3:0]   counter ones digit (BCD)
//   digit_2[3:0]   counter tens digit (BCD)
//   run            counter run enable
//   max_count[6:0] clamped, latched terminal value fed to the counter
//   busy           high in CLEAR or COUNT
//   done           1-cycle pulse when the counter reaches the target
//   err            sticky: bad BCD digit or timeout; cleared by the next accepted start
//   pass_cnt[7:0]  completed passes since the last start, wraps 255->0
module bcd_count_ctrl #(
  parameter int unsigned CLR_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       repeat_en,
  input  logic [6:0] max_req,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  output logic       run,
  output logic [6:0] max_count,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] pass_cnt
);

  localparam int unsigned CLR_W = (CLR_CYCLES > 2) ? $clog2(CLR_CYCLES) : 1;
  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, COUNT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [6:0]       max_d;
  logic [7:0]       pass_d;
  logic             run_d, busy_d, done_d, err_d;
  logic [6:0]       value;
  logic             bad_bcd;

  // Counter value as seen on the digits; only meaningful when both digits are valid BCD.
  assign value   = 7'(digit_2) * 7'd10 + 7'(digit_1);
  assign bad_bcd = (digit_1 > 4'd9) || (digit_2 > 4'd9);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    tmo_d   = tmo_q;
    max_d   = max_count;
    pass_d  = pass_cnt;
    err_d   = err;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (start) begin
            max_d   = (max_req > 7'd99) ? 7'd99 : max_req;
            err_d   = 1'b0;
            pass_d  = 8'd0;
            clr_d   = '0;
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          if (clr_q == CLR_LAST) begin
            tmo_d   = '0;
            state_d = COUNT;
          end else begin
            clr_d = clr_q + CLR_W'(1);
          end
        end
        COUNT: begin
          // A corrupt digit is an error even if the garbled value happens to equal the target.
          // The first COUNT cycle is skipped because the counter output is still settling.
          if (bad_bcd) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if ((tmo_q != '0) && (value == max_count)) begin
            done_d  = 1'b1;
            pass_d  = pass_cnt + 8'd1;
            clr_d   = '0;
            state_d = repeat_en ? CLEAR : HOLD;
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    run_d  = (state_d == COUNT) || (state_d == HOLD);
    busy_d = (state_d == CLEAR) || (state_d == COUNT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_q     <= '0;
      tmo_q     <= '0;
      run       <= 1'b0;
      max_count <= 7'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pass_cnt  <= 8'd0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      tmo_q     <= tmo_d;
      run       <= run_d;
      max_count <= max_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      pass_cnt  <= pass_d;
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench for bcd_count_ctrl: directed vector table, hand sequences, random vs. model.
module tb_bcd_count_ctrl;

  localparam int CLR = 4;
  localparam int TMO = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, repeat_en;
  logic [6:0] max_req;
  logic [3:0] digit_1, digit_2;
  logic       run, busy, done, err;
  logic [6:0] max_count;
  logic [7:0] pass_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  bcd_count_ctrl #(.CLR_CYCLES(CLR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .repeat_en(repeat_en),
    .max_req(max_req), .digit_1(digit_1), .digit_2(digit_2),
    .run(run), .max_count(max_count), .busy(busy), .done(done), .err(err),
    .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s, a, r, q, t, o;
    int e_run, e_max, e_busy, e_done, e_err, e_pass;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int s, a, r, q, t, o, e_run, e_max, e_busy, e_done, e_err, e_pass);
    vec_t v;
    v = '{s, a, r, q, t, o, e_run, e_max, e_busy, e_done, e_err, e_pass};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_run, e_max, e_busy, e_done, e_err, e_pass);
    chk({tag, ".run"},       int'(run),       e_run);
    chk({tag, ".max_count"}, int'(max_count), e_max);
    chk({tag, ".busy"},      int'(busy),      e_busy);
    chk({tag, ".done"},      int'(done),      e_done);
    chk({tag, ".err"},       int'(err),       e_err);
    chk({tag, ".pass_cnt"},  int'(pass_cnt),  e_pass);
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input int s, a, r, q, t, o);
    start     = 1'(s);
    abort     = 1'(a);
    repeat_en = 1'(r);
    max_req   = 7'(q);
    digit_2   = 4'(t);
    digit_1   = 4'(o);
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: phase plus cycles remaining/elapsed in it.
  localparam int P_IDLE = 0, P_CLEAR = 1, P_COUNT = 2, P_HOLD = 3;
  int m_ph, m_left, m_seen, m_max, m_err, m_pass, m_done;

  task automatic model_reset();
    m_ph = P_IDLE; m_left = 0; m_seen = 0; m_max = 0; m_err = 0; m_pass = 0; m_done = 0;
  endtask

  task automatic model_step(input int s, a, r, q, t, o);
    int v;
    bit bad;
    v = 10 * t + o;
    bad = (t > 9) || (o > 9);
    m_done = 0;
    if (a != 0) begin
      m_ph = P_IDLE;
    end else if (m_ph == P_IDLE || m_ph == P_HOLD) begin
      if (s != 0) begin
        m_max = (q > 99) ? 99 : q;
        m_err = 0; m_pass = 0;
        m_ph = P_CLEAR; m_left = CLR - 1;
      end
    end else if (m_ph == P_CLEAR) begin
      if (m_left == 0) begin m_ph = P_COUNT; m_seen = 0; end
      else m_left--;
    end else begin
      if (bad) begin
        m_err = 1; m_ph = P_IDLE;
      end else if (m_seen >= 1 && v == m_max) begin
        m_done = 1;
        m_pass = (m_pass + 1) % 256;
        m_ph = (r != 0) ? P_CLEAR : P_HOLD;
        m_left = CLR - 1;
      end else if (m_seen + 1 >= TMO) begin
        m_err = 1; m_ph = P_IDLE;
      end else begin
        m_seen++;
      end
    end
  endtask

  initial begin
    int bad;
    int rs, ra, rr, rq, rt, ro, val;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    max_req = 7'd0; digit_1 = 4'd0; digit_2 = 4'd0;
    #12;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // s a r  q   t o | run max busy done err pass
    add(1,0,0, 12, 0,0,  0,12,1,0,0,0);
    add(0,0,0, 12, 0,0,  0,12,1,0,0,0);
    add(0,0,0, 12, 0,0,  0,12,1,0,0,0);
    add(0,0,0, 12, 0,0,  0,12,1,0,0,0);
    add(0,0,0, 12, 0,0,  1,12,1,0,0,0);
    add(0,0,0, 18, 1,2,  1,12,1,0,0,0);  // first COUNT cycle ignored; max_req change ignored
    add(0,0,0, 18, 0,5,  1,12,1,0,0,0);
    add(0,0,0, 18, 1,2,  1,12,0,1,0,1);  // match -> HOLD
    add(0,0,0, 18, 1,2,  1,12,0,0,0,1);
    add(1,0,0,118, 1,2,  0,99,1,0,0,0);  // clamp to 99
    add(0,0,0,118, 0,0,  0,99,1,0,0,0);
    add(0,0,0,118, 0,0,  0,99,1,0,0,0);
    add(0,0,0,118, 0,0,  0,99,1,0,0,0);
    add(0,0,0,118, 0,0,  1,99,1,0,0,0);
    add(0,0,0,  0, 9,9,  1,99,1,0,0,0);
    add(0,0,0,  0, 9,9,  1,99,0,1,0,1);
    add(1,0,0,  0, 0,0,  0, 0,1,0,0,0);  // target 0
    add(0,0,0,  0, 0,0,  0, 0,1,0,0,0);
    add(0,0,0,  0, 0,0,  0, 0,1,0,0,0);
    add(0,0,0,  0, 0,0,  0, 0,1,0,0,0);
    add(0,0,0,  0, 0,0,  1, 0,1,0,0,0);
    add(0,0,0,  0, 0,0,  1, 0,1,0,0,0);
    add(0,0,0,  0, 0,0,  1, 0,0,1,0,1);  // match on second COUNT cycle
    add(1,0,0,  7, 0,0,  0, 7,1,0,0,0);
    add(0,0,0,  7, 0,0,  0, 7,1,0,0,0);
    add(0,0,0,  7, 0,0,  0, 7,1,0,0,0);
    add(0,0,0,  7, 0,0,  0, 7,1,0,0,0);
    add(0,0,0,  7, 0,0,  1, 7,1,0,0,0);
    add(0,0,0,  7, 0,1,  1, 7,1,0,0,0);
    add(1,1,0, 20, 0,7,  0, 7,0,0,0,0);  // abort beats start and match
    add(1,0,0, 30, 0,0,  0,30,1,0,0,0);
    add(0,0,0, 30, 0,0,  0,30,1,0,0,0);
    add(0,0,0, 30, 0,0,  0,30,1,0,0,0);
    add(0,0,0, 30, 0,0,  0,30,1,0,0,0);
    add(0,0,0, 30, 0,0,  1,30,1,0,0,0);
    add(1,0,0, 50, 0,0,  1,30,1,0,0,0);  // start in COUNT ignored
    add(0,0,0, 50, 0,10, 0,30,0,0,1,0);  // bad BCD
    add(0,0,0, 50, 0,0,  0,30,0,0,1,0);
    add(1,0,0, 30, 0,0,  0,30,1,0,0,0);  // start clears err
    add(0,1,0, 30, 0,0,  0,30,0,0,0,0);  // abort in CLEAR

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s, vecs[i].a, vecs[i].r, vecs[i].q, vecs[i].t, vecs[i].o);
      check_all($sformatf("vec%0d", i), vecs[i].e_run, vecs[i].e_max, vecs[i].e_busy,
                vecs[i].e_done, vecs[i].e_err, vecs[i].e_pass);
    end

    // Repeated passes: run low CLR cycles between passes, pass_cnt climbs, drop repeat -> HOLD.
    step(1,0,1,5,0,0);
    check_all("rep_start", 0, 5, 1, 0, 0, 0);
    for (int p = 1; p <= 4; p++) begin
      int r;
      r = (p < 4) ? 1 : 0;
      for (int k = 0; k < CLR - 1; k++) begin
        step(0,0,r,5,0,0);
        check_all("rep_clear", 0, 5, 1, 0, 0, p - 1);
      end
      step(0,0,r,5,0,0);
      check_all("rep_cnt0", 1, 5, 1, 0, 0, p - 1);
      step(0,0,r,5,0,5);
      check_all("rep_skip", 1, 5, 1, 0, 0, p - 1);
      step(0,0,r,5,0,5);
      if (p < 4) check_all("rep_done", 0, 5, 1, 1, 0, p);
      else       check_all("rep_hold", 1, 5, 0, 1, 0, p);
    end

    // Timeout: digits frozen below target.
    step(1,0,0,50,1,0);
    check_all("tmo_start", 0, 50, 1, 0, 0, 0);
    for (int k = 0; k < CLR - 1; k++) step(0,0,0,50,1,0);
    step(0,0,0,50,1,0);
    check_all("tmo_cnt0", 1, 50, 1, 0, 0, 0);
    bad = 0;
    for (int k = 0; k < TMO - 1; k++) begin
      step(0,0,0,50,1,0);
      if (done || err || !run) bad++;
    end
    chk("tmo_early", bad, 0);
    step(0,0,0,50,1,0);
    check_all("tmo_err", 0, 50, 0, 0, 1, 0);

    // Asynchronous reset mid-COUNT after one completed pass.
    step(1,0,1,3,0,0);
    for (int k = 0; k < CLR - 1; k++) step(0,0,1,3,0,0);
    step(0,0,1,3,0,0);
    step(0,0,1,3,0,3);
    step(0,0,1,3,0,3);
    check_all("rst_pre_done", 0, 3, 1, 1, 0, 1);
    for (int k = 0; k < CLR - 1; k++) step(0,0,1,3,0,0);
    step(0,0,1,3,0,0);
    check_all("rst_pre_cnt", 1, 3, 1, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1 check_all("rst_async", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat_en = 1'b0;

    // Random stimulus against the reference model.
    model_reset();
    rr = 0;
    for (int n = 0; n < 3000; n++) begin
      rs = ($urandom_range(0, 9) == 0) ? 1 : 0;
      ra = ($urandom_range(0, 59) == 0) ? 1 : 0;
      if ($urandom_range(0, 49) == 0) rr = 1 - rr;
      rq = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 12));
      val = int'($urandom_range(0, 12));
      rt = val / 10;
      ro = val % 10;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 0) ro = int'($urandom_range(10, 15));
        else                           rt = int'($urandom_range(10, 15));
      end
      model_step(rs, ra, rr, rq, rt, ro);
      step(rs, ra, rr, rq, rt, ro);
      check_all("rand",
                (m_ph == P_COUNT || m_ph == P_HOLD) ? 1 : 0, m_max,
                (m_ph == P_CLEAR || m_ph == P_COUNT) ? 1 : 0,
                m_done, m_err, m_pass);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
